// File: rtl/serial_mag_comparator.sv
// Multi-cycle magnitude comparator: walks the operands MSB-first, SLICE bits per clock,
// and stops at the first differing slice. Result flags are held until the next decision.
module serial_mag_comparator #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NSLICE - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: start is taken on any edge where busy==0; done pulses for one cycle on the
  // decision edge, in which gt/eq/lt take their new values and busy drops.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [IDXW-1:0]  idx;
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;

  // Operands are shifted left after each equal slice, so the live slice is always on top.
  assign slice_a = op_a[WIDTH-1 -: SLICE];
  assign slice_b = op_b[WIDTH-1 -: SLICE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Flipping the sign bit maps two's-complement order onto unsigned order.
            op_a  <= a ^ (signed_mode ? MSB_MASK : '0);
            op_b  <= b ^ (signed_mode ? MSB_MASK : '0);
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (slice_a != slice_b) begin
            gt    <= (slice_a > slice_b);
            lt    <= (slice_a < slice_b);
            eq    <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (idx == LAST_IDX) begin
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            idx  <= idx + IDXW'(1);
            op_a <= op_a << SLICE;
            op_b <= op_b << SLICE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
